// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA key-generation datapath.
package rsa_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ARM,
    ARB_RUN,
    ARB_RESP
  } mr_arb_state_t;

  localparam int unsigned DEFAULT_MR_TIMEOUT = 4096;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping around.
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] j;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = IW'((32'(rr_ptr) + i) % N);
      if (!valid && req[j]) begin
        valid   = 1'b1;
        pick[j] = 1'b1;
        idx     = j;
      end
    end
  end

endmodule

// File: rtl/primality_test_arbiter.sv
// Shares one Miller-Rabin core among NUM_REQ requesters with round-robin grant,
// trivial-candidate short cut and a watchdog on each core run.
module primality_test_arbiter
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned SEC_PARAM      = 1,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_MR_TIMEOUT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*(WORD_WIDTH/2)-1:0]   req_n,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic                                resp_is_prime,
  output logic                                resp_timeout,
  output logic                                busy,
  output logic                                mr_rst,
  output logic                                mr_enable,
  output logic [WORD_WIDTH/2-1:0]             mr_n,
  output logic [1:0]                          mr_security_param,
  input  logic                                mr_done,
  input  logic                                mr_is_prime
);

  localparam int unsigned NW = WORD_WIDTH / 2;
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  mr_arb_state_t        state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic                 resp_is_prime_q, resp_is_prime_d;
  logic                 resp_timeout_q, resp_timeout_d;
  logic                 busy_q, busy_d;
  logic                 mr_rst_q, mr_rst_d;
  logic                 mr_enable_q, mr_enable_d;
  logic [NW-1:0]        mr_n_q, mr_n_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        wdog_q, wdog_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [IW-1:0]        next_ptr;
  logic [CW-1:0]        wdog_inc;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign wdog_inc = wdog_q + CW'(1);

  // Next-state, verdict and registered-output computation.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    resp_valid_d    = '0;
    resp_is_prime_d = 1'b0;
    resp_timeout_d  = 1'b0;
    mr_n_d          = mr_n_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    wdog_d          = wdog_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_ARM;
          grant_d = pick_oh;
          owner_d = pick_idx;
          mr_n_d  = req_n[32'(pick_idx) * NW +: NW];
          wdog_d  = '0;
        end
      end
      ARB_ARM: begin
        if (!req[owner_q]) begin
          state_d  = ARB_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end else if (mr_n_q < NW'(2)) begin
          state_d      = ARB_RESP;
          resp_valid_d = grant_q;
        end else if ((mr_n_q == NW'(2)) || (mr_n_q == NW'(3))) begin
          state_d         = ARB_RESP;
          resp_valid_d    = grant_q;
          resp_is_prime_d = 1'b1;
        end else if (!mr_n_q[0]) begin
          state_d      = ARB_RESP;
          resp_valid_d = grant_q;
        end else begin
          state_d = ARB_RUN;
        end
      end
      ARB_RUN: begin
        if (!req[owner_q]) begin
          state_d  = ARB_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end else begin
          wdog_d = wdog_inc;
          // A done arriving on the expiry cycle still counts as a real verdict.
          if (mr_done) begin
            state_d         = ARB_RESP;
            resp_valid_d    = grant_q;
            resp_is_prime_d = mr_is_prime;
          end else if (wdog_inc == CW'(TIMEOUT_CYCLES)) begin
            state_d        = ARB_RESP;
            resp_valid_d   = grant_q;
            resp_timeout_d = 1'b1;
          end
        end
      end
      ARB_RESP: begin
        state_d  = ARB_IDLE;
        grant_d  = '0;
        rr_ptr_d = next_ptr;
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d      = (state_d != ARB_IDLE);
    mr_rst_d    = (state_d == ARB_ARM);
    mr_enable_d = (state_d == ARB_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ARB_IDLE;
      grant_q         <= '0;
      resp_valid_q    <= '0;
      resp_is_prime_q <= 1'b0;
      resp_timeout_q  <= 1'b0;
      busy_q          <= 1'b0;
      mr_rst_q        <= 1'b1;
      mr_enable_q     <= 1'b0;
      mr_n_q          <= '0;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      wdog_q          <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      resp_valid_q    <= resp_valid_d;
      resp_is_prime_q <= resp_is_prime_d;
      resp_timeout_q  <= resp_timeout_d;
      busy_q          <= busy_d;
      mr_rst_q        <= mr_rst_d;
      mr_enable_q     <= mr_enable_d;
      mr_n_q          <= mr_n_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      wdog_q          <= wdog_d;
    end
  end

  assign grant             = grant_q;
  assign resp_valid        = resp_valid_q;
  assign resp_is_prime     = resp_is_prime_q;
  assign resp_timeout      = resp_timeout_q;
  assign busy              = busy_q;
  assign mr_rst            = mr_rst_q;
  assign mr_enable         = mr_enable_q;
  assign mr_n              = mr_n_q;
  assign mr_security_param = 2'(SEC_PARAM);

endmodule

// File: tb/tb_primality_test_arbiter.sv
// Bench for primality_test_arbiter: a fake Miller-Rabin core driven from tasks,
// expectations from trial-division primality and a round-robin owner model.
module tb_primality_test_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned NW = 16;
  localparam int          TO = 24;
  localparam int          BUDGET = TO + 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*NW-1:0] req_n;
  logic [NR-1:0] grant, resp_valid;
  logic          resp_is_prime, resp_timeout, busy, mr_rst, mr_enable;
  logic [NW-1:0] mr_n;
  logic [1:0]    mr_security_param;
  logic          mr_done, mr_is_prime;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;

  // Observations gathered by serve()
  int            obs_cyc, obs_en, obs_rst;
  logic [NR-1:0] obs_valid, obs_grant;
  logic          obs_prime, obs_to, obs_stable, obs_idle;
  logic [NW-1:0] obs_mrn;

  primality_test_arbiter #(
    .WORD_WIDTH     (32),
    .NUM_REQ        (NR),
    .SEC_PARAM      (1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .req_n             (req_n),
    .grant             (grant),
    .resp_valid        (resp_valid),
    .resp_is_prime     (resp_is_prime),
    .resp_timeout      (resp_timeout),
    .busy              (busy),
    .mr_rst            (mr_rst),
    .mr_enable         (mr_enable),
    .mr_n              (mr_n),
    .mr_security_param (mr_security_param),
    .mr_done           (mr_done),
    .mr_is_prime       (mr_is_prime)
  );

  always #5 clk = ~clk;

  function automatic bit ref_prime(input int unsigned n);
    if (n < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int ref_pick(input logic [NR-1:0] r, input int p);
    for (int i = 0; i < NR; i++)
      if (r[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  function automatic bit ref_trivial(input int unsigned n);
    return (n < 4) || (n % 2 == 0);
  endfunction

  function automatic bit ref_tmo(input int unsigned n, input int lat);
    return !ref_trivial(n) && (lat == 0 || lat > TO);
  endfunction

  function automatic int ref_cycles(input int unsigned n, input int lat);
    if (ref_trivial(n)) return 2;
    if (ref_tmo(n, lat)) return 2 + TO;
    return 2 + lat;
  endfunction

  function automatic int ref_en(input int unsigned n, input int lat);
    if (ref_trivial(n)) return 0;
    if (ref_tmo(n, lat)) return TO;
    return lat;
  endfunction

  // Runs one request from an IDLE cycle; the fake core answers after lat enable cycles (0 = never).
  task automatic serve(input logic [NR-1:0] req_v, input logic [NR*NW-1:0] n_v, input int lat,
                       input logic noise, input logic core_prime);
    int en_cnt;
    req = req_v; req_n = n_v; mr_done = 1'b0; mr_is_prime = 1'b0;
    obs_cyc = -1; obs_en = 0; obs_rst = 0; obs_valid = '0; obs_grant = '0;
    obs_prime = 1'b0; obs_to = 1'b0; obs_stable = 1'b1; obs_idle = 1'b0; obs_mrn = '0;
    en_cnt = 0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (mr_rst) obs_rst++;
      if (mr_enable) obs_en++;
      if (c == 1) begin
        obs_grant = grant;
        obs_mrn   = mr_n;
      end else if (mr_n !== obs_mrn) begin
        obs_stable = 1'b0;
      end
      if (resp_valid !== '0) begin
        obs_cyc = c; obs_valid = resp_valid; obs_prime = resp_is_prime; obs_to = resp_timeout;
        break;
      end
      if (mr_enable) begin
        en_cnt++;
        mr_done     = (lat > 0) && (en_cnt == lat);
        mr_is_prime = core_prime;
      end else begin
        mr_done     = noise;
        mr_is_prime = noise;
      end
    end
    mr_done = 1'b0; mr_is_prime = 1'b0;
    @(posedge clk); #1;
    obs_idle = (busy === 1'b0) && (grant === '0) && (resp_valid === '0) && (mr_enable === 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_n = '0; mr_done = 1'b0; mr_is_prime = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ptr_m = 0;
  endtask

  task automatic test_reset();
    logic [30:0] got;
    do_reset();
    got = {grant, resp_valid, resp_is_prime, resp_timeout, busy, mr_rst, mr_enable, mr_n};
    n_tests++;
    if (got !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", got, {4'b0, 4'b0, 5'b00010, 16'h0});
    end
    n_tests++;
    if (mr_security_param !== 2'd1) begin
      n_fail++; $display("FAIL sec_param: got %0d want 1", mr_security_param);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({mr_rst, busy, grant} !== 6'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 000000", {mr_rst, busy, grant});
    end
  endtask

  task automatic test_single();
    serve(4'b0001, {48'h0, 16'd97}, 20, 1'b0, 1'b1);
    n_tests++;
    if ({obs_valid, obs_prime, obs_to} !== 6'b0001_1_0) begin
      n_fail++; $display("FAIL single_verdict: got %b want 000110", {obs_valid, obs_prime, obs_to});
    end
    n_tests++;
    if (obs_cyc !== 22 || obs_en !== 20 || obs_rst !== 1) begin
      n_fail++; $display("FAIL single_timing: got cyc=%0d en=%0d rst=%0d want 22/20/1", obs_cyc, obs_en, obs_rst);
    end
    n_tests++;
    if (obs_grant !== 4'b0001 || obs_mrn !== 16'd97 || !obs_stable || !obs_idle) begin
      n_fail++; $display("FAIL single_handshake: got grant=%b mr_n=%0d stable=%b idle=%b want 0001/97/1/1",
                         obs_grant, obs_mrn, obs_stable, obs_idle);
    end
    ptr_m = 1;
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [NR*NW-1:0] nv;
    logic [NR-1:0] ev;
    int ow;
    do_reset();
    rst = 1'b0;
    nv = {16'd65521, 16'd13, 16'd91, 16'd101};
    for (int k = 0; k < 5; k++) begin
      ow = ref_pick(4'hF, ptr_m);
      ev = 4'(1 << ow);
      serve(4'hF, nv, 5, 1'b0, ref_prime(32'(nv[ow*NW +: NW])));
      n_tests++;
      if (obs_valid !== ev || obs_grant !== ev || obs_cyc !== 7 || !obs_idle) begin
        n_fail++; $display("FAIL rr_order[%0d]: got valid=%b grant=%b cyc=%0d want %b/%b/7",
                           k, obs_valid, obs_grant, obs_cyc, ev, ev);
      end
      n_tests++;
      if (obs_prime !== ref_prime(32'(nv[ow*NW +: NW])) || obs_to !== 1'b0) begin
        n_fail++; $display("FAIL rr_verdict[%0d]: got %b%b want %b0", k, obs_prime, obs_to,
                           ref_prime(32'(nv[ow*NW +: NW])));
      end
      ptr_m = (ow + 1) % NR;
    end
    req = '0;
  endtask

  task automatic test_trivial();
    int unsigned tv[6];
    logic [NR*NW-1:0] nv;
    int ow;
    tv = '{0, 1, 2, 3, 100, 65534};
    for (int k = 0; k < 6; k++) begin
      ow = ptr_m;
      nv = {$urandom, $urandom};
      nv[ow*NW +: NW] = NW'(tv[k]);
      serve(4'(1 << ow), nv, 1, 1'b1, 1'b1);
      n_tests++;
      if (obs_valid !== 4'(1 << ow) || obs_prime !== ref_prime(tv[k]) || obs_to !== 1'b0) begin
        n_fail++; $display("FAIL trivial_verdict n=%0d: got valid=%b prime=%b to=%b want %b/%b/0",
                           tv[k], obs_valid, obs_prime, obs_to, 4'(1 << ow), ref_prime(tv[k]));
      end
      n_tests++;
      if (obs_cyc !== 2 || obs_en !== 0 || obs_rst !== 1) begin
        n_fail++; $display("FAIL trivial_timing n=%0d: got cyc=%0d en=%0d rst=%0d want 2/0/1",
                           tv[k], obs_cyc, obs_en, obs_rst);
      end
      ptr_m = (ow + 1) % NR;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    serve(4'b1000, {16'd97, 48'h0}, 0, 1'b0, 1'b1);
    n_tests++;
    if ({obs_valid, obs_prime, obs_to} !== 6'b1000_0_1 || obs_cyc !== 2 + TO || obs_en !== TO) begin
      n_fail++; $display("FAIL timeout: got %b cyc=%0d en=%0d want 100001 cyc=%0d en=%0d",
                         {obs_valid, obs_prime, obs_to}, obs_cyc, obs_en, 2 + TO, TO);
    end
    ptr_m = 0;
    serve(4'b0010, {32'h0, 16'd97, 16'h0}, TO, 1'b0, 1'b1);
    n_tests++;
    if ({obs_valid, obs_prime, obs_to} !== 6'b0010_1_0 || obs_cyc !== 2 + TO) begin
      n_fail++; $display("FAIL done_at_expiry: got %b cyc=%0d want 001010 cyc=%0d",
                         {obs_valid, obs_prime, obs_to}, obs_cyc, 2 + TO);
    end
    ptr_m = 2;
    req = '0;
  endtask

  task automatic test_drop();
    int  en_seen;
    bit  seen_valid;
    req = 4'b0100; req_n = {16'h0, 16'd97, 32'h0}; mr_done = 1'b0;
    en_seen = 0; seen_valid = 1'b0;
    for (int c = 0; c < BUDGET && en_seen < 5; c++) begin
      @(posedge clk); #1;
      if (mr_enable) en_seen++;
      if (resp_valid !== '0) seen_valid = 1'b1;
    end
    req = '0;
    @(posedge clk); #1;
    n_tests++;
    if (en_seen != 5 || seen_valid || {busy, grant, resp_valid, mr_enable} !== 10'b0) begin
      n_fail++; $display("FAIL drop_abort: got en=%0d valid_seen=%b state=%b want 5/0/0",
                         en_seen, seen_valid, {busy, grant, resp_valid, mr_enable});
    end
    ptr_m = 3;
    serve(4'b0101, {16'h0, 16'd97, 16'h0, 16'd97}, 3, 1'b0, 1'b1);
    n_tests++;
    if (obs_valid !== 4'(1 << ref_pick(4'b0101, ptr_m)) || obs_cyc !== 5) begin
      n_fail++; $display("FAIL drop_ptr_advance: got valid=%b cyc=%0d want %b cyc=5",
                         obs_valid, obs_cyc, 4'(1 << ref_pick(4'b0101, ptr_m)));
    end
    ptr_m = 1;
    req = '0;
  endtask

  task automatic test_rst_mid_run();
    int  en_seen;
    logic [30:0] got;
    req = 4'b0010; req_n = {32'h0, 16'd1009, 16'h0}; mr_done = 1'b0;
    en_seen = 0;
    for (int c = 0; c < BUDGET && en_seen < 3; c++) begin
      @(posedge clk); #1;
      if (mr_enable) en_seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    got = {grant, resp_valid, resp_is_prime, resp_timeout, busy, mr_rst, mr_enable, mr_n};
    n_tests++;
    if (en_seen != 3 || got !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL rst_mid_run: got en=%0d outs=%h want 3/%h", en_seen, got,
                         {4'b0, 4'b0, 5'b00010, 16'h0});
    end
    req = '0; rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, resp_valid, mr_rst} !== 6'b0) begin
      n_fail++; $display("FAIL rst_recover: got %b want 000000", {busy, resp_valid, mr_rst});
    end
    ptr_m = 0;
  endtask

  task automatic test_random();
    logic [NR-1:0] rv;
    logic [NR*NW-1:0] nv;
    int lat, ow;
    int unsigned n;
    bit cp, tm;
    for (int k = 0; k < 20; k++) begin
      rv = 4'($urandom_range(1, 15));
      for (int s = 0; s < NR; s++)
        nv[s*NW +: NW] = ($urandom_range(0, 2) == 0) ? NW'($urandom_range(0, 9))
                                                      : NW'($urandom | 1);
      lat = $urandom_range(0, TO + 4);
      ow  = ref_pick(rv, ptr_m);
      n   = 32'(nv[ow*NW +: NW]);
      cp  = ref_prime(n);
      tm  = ref_tmo(n, lat);
      serve(rv, nv, lat, 1'($urandom), cp);
      n_tests++;
      if (obs_valid !== 4'(1 << ow) || obs_prime !== (cp && !tm) || obs_to !== tm) begin
        n_fail++; $display("FAIL rand_verdict[%0d] n=%0d lat=%0d: got %b %b %b want %b %b %b", k, n, lat,
                           obs_valid, obs_prime, obs_to, 4'(1 << ow), cp && !tm, tm);
      end
      n_tests++;
      if (obs_cyc !== ref_cycles(n, lat) || obs_en !== ref_en(n, lat) || obs_mrn !== NW'(n)
          || !obs_stable || !obs_idle) begin
        n_fail++; $display("FAIL rand_timing[%0d] n=%0d lat=%0d: got cyc=%0d en=%0d mr_n=%0d want %0d/%0d/%0d",
                           k, n, lat, obs_cyc, obs_en, obs_mrn, ref_cycles(n, lat), ref_en(n, lat), n);
      end
      ptr_m = (ow + 1) % NR;
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_trivial();
    test_timeout();
    test_drop();
    test_rst_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
